change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter CNT_W, default 8, per-bin coin count width.
REQ-002 SHALL have parameter AMT_W, default 8, request amount width in nickel units (1 unit = 5 cents).
REQ-003 SHALL have parameter LOW_THRESH, default 2, low-stock threshold applied to every bin.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its falling edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port load  input  1  bin reload strobe.
REQ-007 SHALL have ports nickels, dimes, quarters  input  CNT_W each  reload values.
REQ-008 SHALL have port req_valid  input  1  change request valid.
REQ-009 SHALL have port req_amount  input  AMT_W  change requested, nickel units.
REQ-010 SHALL have port req_ready  output  1  request can be accepted.
REQ-011 SHALL have port coin_out  output  3  one-hot one-cycle coin strobe: bit0 nickel, bit1 dime, bit2 quarter.
REQ-012 SHALL have port done  output  1  one-cycle pulse, request fully paid.
REQ-013 SHALL have port short  output  1  one-cycle pulse, request could not be completed ("use exact change").
REQ-014 SHALL have port short_amount  output  AMT_W  unpaid remainder, valid while short=1.
REQ-015 SHALL have ports nickel_count, dime_count, quarter_count  output  CNT_W each  current bin contents.
REQ-016 SHALL have port low  output  3  per-bin flag, bit set when count <= LOW_THRESH; same bit order as coin_out.
REQ-017 SHALL have port empty  output  1  high when all three counts are zero.

Function
REQ-018 SHALL use coin values nickel=1, dime=2, quarter=5 nickel units.
REQ-019 SHALL implement FSM states IDLE and DISPENSE.
REQ-020 SHALL drive req_ready = (state==IDLE) && !load, combinationally.
REQ-021 SHALL, in IDLE on an edge with load=1, copy nickels/dimes/quarters into the bins; load outside IDLE is ignored.
REQ-022 SHALL accept a request on an edge with req_valid && req_ready, latch req_amount as remaining, and enter DISPENSE.
REQ-023 SHALL, on each DISPENSE edge, pick the largest coin with value <= remaining and bin count != 0 (quarter, then dime, then nickel), decrement that bin by 1, subtract its value from remaining, and pulse that coin_out bit for one cycle.
REQ-024 SHALL, on the DISPENSE edge where remaining becomes 0, pulse done together with the final coin_out and return to IDLE.
REQ-025 SHALL, on a DISPENSE edge where remaining != 0 and no coin qualifies, dispense nothing, pulse short, set short_amount = remaining, and return to IDLE.
REQ-026 SHALL treat req_amount=0 as complete: done pulses on the first DISPENSE edge, with no coin.
REQ-027 SHALL dispense at most one coin per cycle; a request needing N coins therefore completes N edges after acceptance.
REQ-028 SHALL never decrement a zero bin (no wrap-around) and SHALL never let remaining go negative.
REQ-029 SHALL keep coin_out, done and short low on every edge not listed above; done and short are never high together.
REQ-030 SHALL derive empty and low combinationally from the current counts.

Reset
REQ-031 SHALL, on rst_n=0 regardless of clk, go to IDLE with all bins=0, remaining=0, coin_out=0, done=0, short=0 and short_amount=0; empty=1 and low=3'b111 follow from the zero counts.
REQ-032 SHALL abandon a request in progress at reset with no done or short pulse, and drive no coin output while rst_n=0.

Verification
REQ-033 SHALL pass: load n=3,d=2,q=1; request 9 -> quarter, dime, dime on consecutive cycles, done with the last; counts 3/0/0; low=3'b110.
REQ-034 SHALL pass: bins n=4,d=0,q=0; request 3 -> three nickels, done; counts 1/0/0.
REQ-035 SHALL pass: bins n=1,d=0,q=1; request 8 -> quarter, nickel, then short with short_amount=2; counts 0/0/0, empty=1.
REQ-036 SHALL pass: load pulsed during DISPENSE -> ignored, counts unchanged by load; req_ready=0 while load=1 in IDLE.
REQ-037 SHALL pass: request 0 -> done one edge after accept, coin_out stays 0.
REQ-038 SHALL pass: rst_n low mid-request (after 1 of 3 coins) -> IDLE, counts 0, no done/short, req_ready=1 after release.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser
//   Greedy coin-change dispenser with three coin bins (nickel, dime, quarter).
//   Amounts are in nickel units: nickel=1, dime=2, quarter=5.
//   A request is paid one coin per cycle, largest qualifying coin first.
//   If no stocked coin fits the remainder, the request ends with a short
//   pulse that reports the unpaid remainder.
//   State changes on the falling clock edge. Reset is asynchronous and active-low.
//
// Ports
//   clk, rst_n                    clock (falling-edge active), async active-low reset
//   load                          reload strobe, only honoured in IDLE
//   nickels, dimes, quarters      reload values
//   req_valid, req_amount         change request (nickel units)
//   req_ready                     request can be accepted this cycle
//   coin_out                      one-hot coin strobe {quarter, dime, nickel}
//   done                          request fully paid (one-cycle pulse)
//   short                         request could not be completed (one-cycle pulse)
//   short_amount                  unpaid remainder, valid while short=1
//   nickel/dime/quarter_count     current bin contents
//   low                           per-bin count <= LOW_THRESH, same bit order as coin_out
//   empty                         all bins are zero
module change_dispenser #(
   parameter int CNT_W      = 8,
   parameter int AMT_W      = 8,
   parameter int LOW_THRESH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] nickels,
   input  logic [CNT_W-1:0] dimes,
   input  logic [CNT_W-1:0] quarters,
   input  logic             req_valid,
   input  logic [AMT_W-1:0] req_amount,
   output logic             req_ready,
   output logic [2:0]       coin_out,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] short_amount,
   output logic [CNT_W-1:0] nickel_count,
   output logic [CNT_W-1:0] dime_count,
   output logic [CNT_W-1:0] quarter_count,
   output logic [2:0]       low,
   output logic             empty
);

   typedef enum logic {IDLE, DISPENSE} state_t;

   state_t           state, state_nx;
   logic [AMT_W-1:0] remaining, remaining_nx;
   logic [CNT_W-1:0] nickel_nx, dime_nx, quarter_nx;
   logic [2:0]       coin_nx;
   logic             done_nx, short_nx;
   logic [AMT_W-1:0] short_amount_nx;
   logic [AMT_W-1:0] coin_val;
   logic             coin_ok;

   assign req_ready = (state == IDLE) && !load;

   assign low[0] = (nickel_count  <= CNT_W'(LOW_THRESH));
   assign low[1] = (dime_count    <= CNT_W'(LOW_THRESH));
   assign low[2] = (quarter_count <= CNT_W'(LOW_THRESH));
   assign empty  = (nickel_count == '0) && (dime_count == '0) && (quarter_count == '0);

   always_comb begin
      state_nx        = state;
      remaining_nx    = remaining;
      nickel_nx       = nickel_count;
      dime_nx         = dime_count;
      quarter_nx      = quarter_count;
      coin_nx         = 3'b000;
      done_nx         = 1'b0;
      short_nx        = 1'b0;
      short_amount_nx = short_amount;
      coin_val        = '0;
      coin_ok         = 1'b0;

      case (state)
         IDLE: begin
            if (load) begin
               nickel_nx  = nickels;
               dime_nx    = dimes;
               quarter_nx = quarters;
            end else if (req_valid) begin
               remaining_nx = req_amount;
               state_nx     = DISPENSE;
            end
         end
         DISPENSE: begin
            // Greedy pick: the coin must fit the remainder and its bin must be stocked,
            // which keeps both the bins and the remainder from underflowing.
            if (remaining >= AMT_W'(5) && quarter_count != '0) begin
               coin_ok    = 1'b1;
               coin_val   = AMT_W'(5);
               coin_nx    = 3'b100;
               quarter_nx = quarter_count - CNT_W'(1);
            end else if (remaining >= AMT_W'(2) && dime_count != '0) begin
               coin_ok  = 1'b1;
               coin_val = AMT_W'(2);
               coin_nx  = 3'b010;
               dime_nx  = dime_count - CNT_W'(1);
            end else if (remaining >= AMT_W'(1) && nickel_count != '0) begin
               coin_ok   = 1'b1;
               coin_val  = AMT_W'(1);
               coin_nx   = 3'b001;
               nickel_nx = nickel_count - CNT_W'(1);
            end

            if (remaining == '0) begin
               // zero-amount request completes with no coin
               done_nx  = 1'b1;
               state_nx = IDLE;
            end else if (coin_ok) begin
               remaining_nx = remaining - coin_val;
               if (remaining == coin_val) begin
                  done_nx  = 1'b1;
                  state_nx = IDLE;
               end
            end else begin
               short_nx        = 1'b1;
               short_amount_nx = remaining;
               state_nx        = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         remaining     <= '0;
         nickel_count  <= '0;
         dime_count    <= '0;
         quarter_count <= '0;
         coin_out      <= 3'b000;
         done          <= 1'b0;
         short         <= 1'b0;
         short_amount  <= '0;
      end else begin
         state         <= state_nx;
         remaining     <= remaining_nx;
         nickel_count  <= nickel_nx;
         dime_count    <= dime_nx;
         quarter_count <= quarter_nx;
         coin_out      <= coin_nx;
         done          <= done_nx;
         short         <= short_nx;
         short_amount  <= short_amount_nx;
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

   localparam int CNT_W = 8;
   localparam int AMT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             load = 1'b0;
   logic [CNT_W-1:0] nickels = '0, dimes = '0, quarters = '0;
   logic             req_valid = 1'b0;
   logic [AMT_W-1:0] req_amount = '0;
   logic             req_ready;
   logic [2:0]       coin_out;
   logic             done, short;
   logic [AMT_W-1:0] short_amount;
   logic [CNT_W-1:0] nickel_count, dime_count, quarter_count;
   logic [2:0]       low;
   logic             empty;

   change_dispenser #(.CNT_W(CNT_W), .AMT_W(AMT_W), .LOW_THRESH(2)) dut (
      .clk(clk), .rst_n(rst_n), .load(load),
      .nickels(nickels), .dimes(dimes), .quarters(quarters),
      .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
      .coin_out(coin_out), .done(done), .short(short), .short_amount(short_amount),
      .nickel_count(nickel_count), .dime_count(dime_count), .quarter_count(quarter_count),
      .low(low), .empty(empty)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int seen[$];

   typedef struct {
      int n, d, q, amt;
      int coins, edges, res, samt, first;
      int en, ed, eq;
      int lw;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // one active (falling) edge, then settle before sampling/driving
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_load(input int n, input int d, input int q);
      nickels = CNT_W'(n); dimes = CNT_W'(d); quarters = CNT_W'(q);
      load = 1'b1;
      #1;
      chk("ready_during_load", int'(req_ready), 0);
      step();
      load = 1'b0;
   endtask

   // res: 1 = done, 2 = short, 0 = no completion within the bound
   task automatic run_req(input int amt, output int edges, output int res, output int samt);
      req_amount = AMT_W'(amt);
      req_valid  = 1'b1;
      #1;
      chk("ready_before_accept", int'(req_ready), 1);
      step();
      req_valid = 1'b0;
      seen.delete();
      edges = 0; res = 0; samt = -1;
      for (int i = 0; i < 300 && res == 0; i++) begin
         step();
         edges++;
         if (coin_out != 3'b000) seen.push_back(int'(coin_out));
         if (done && short) chk("done_and_short", 1, 0);
         if (done) res = 1;
         else if (short) begin
            res  = 2;
            samt = int'(short_amount);
         end
      end
      if (res == 0) chk("completion_timeout", 0, 1);
   endtask

   int m_n, m_d, m_q;
   int exp_q[$];

   // Reference: walk the greedy rule with plain integers, yielding the
   // expected coin list and the final outcome.
   task automatic model_req(input int amt, output int res, output int samt);
      int r;
      r = amt;
      exp_q.delete();
      res = 0; samt = -1;
      while (res == 0) begin
         if (r == 0) res = 1;
         else if (r >= 5 && m_q > 0) begin m_q--; r -= 5; exp_q.push_back(4); end
         else if (r >= 2 && m_d > 0) begin m_d--; r -= 2; exp_q.push_back(2); end
         else if (r >= 1 && m_n > 0) begin m_n--; r -= 1; exp_q.push_back(1); end
         else begin res = 2; samt = r; end
      end
   endtask

   initial begin
      int edges, res, samt, e_res, e_samt, e_edges, orv;

      vecs[0] = '{n:3,  d:2,  q:1,  amt:9,  coins:3, edges:3, res:1, samt:0, first:4, en:3,  ed:0, eq:0, lw:6};
      vecs[1] = '{n:4,  d:0,  q:0,  amt:3,  coins:3, edges:3, res:1, samt:0, first:1, en:1,  ed:0, eq:0, lw:7};
      vecs[2] = '{n:1,  d:0,  q:1,  amt:8,  coins:2, edges:3, res:2, samt:2, first:4, en:0,  ed:0, eq:0, lw:7};
      vecs[3] = '{n:5,  d:5,  q:5,  amt:0,  coins:0, edges:1, res:1, samt:0, first:0, en:5,  ed:5, eq:5, lw:0};
      vecs[4] = '{n:0,  d:0,  q:0,  amt:4,  coins:0, edges:1, res:2, samt:4, first:0, en:0,  ed:0, eq:0, lw:7};
      vecs[5] = '{n:0,  d:3,  q:2,  amt:11, coins:2, edges:3, res:2, samt:1, first:4, en:0,  ed:3, eq:0, lw:5};
      vecs[6] = '{n:10, d:10, q:10, amt:17, coins:4, edges:4, res:1, samt:0, first:4, en:10, ed:9, eq:7, lw:0};

      // reset state, sampled while rst_n is held low
      #2;
      chk("rst_nickel", int'(nickel_count), 0);
      chk("rst_dime", int'(dime_count), 0);
      chk("rst_quarter", int'(quarter_count), 0);
      chk("rst_coin", int'(coin_out), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_short", int'(short), 0);
      chk("rst_short_amount", int'(short_amount), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_low", int'(low), 7);
      chk("rst_ready", int'(req_ready), 1);
      step();
      rst_n = 1'b1;
      step();

      // table-driven scenarios
      for (int v = 0; v < 7; v++) begin
         do_load(vecs[v].n, vecs[v].d, vecs[v].q);
         run_req(vecs[v].amt, edges, res, samt);
         chk($sformatf("v%0d_result", v), res, vecs[v].res);
         chk($sformatf("v%0d_edges", v), edges, vecs[v].edges);
         chk($sformatf("v%0d_coins", v), seen.size(), vecs[v].coins);
         if (vecs[v].coins > 0 && seen.size() > 0)
            chk($sformatf("v%0d_first_coin", v), seen[0], vecs[v].first);
         if (vecs[v].res == 2) chk($sformatf("v%0d_short_amount", v), samt, vecs[v].samt);
         chk($sformatf("v%0d_nickels", v), int'(nickel_count), vecs[v].en);
         chk($sformatf("v%0d_dimes", v), int'(dime_count), vecs[v].ed);
         chk($sformatf("v%0d_quarters", v), int'(quarter_count), vecs[v].eq);
         chk($sformatf("v%0d_low", v), int'(low), vecs[v].lw);
         chk($sformatf("v%0d_empty", v), int'(empty), int'(vecs[v].en + vecs[v].ed + vecs[v].eq == 0));
         step();
         chk($sformatf("v%0d_pulse_gone", v), int'({coin_out, done, short}), 0);
      end

      // load pulsed while dispensing must be ignored
      do_load(5, 5, 5);
      req_amount = AMT_W'(10);
      req_valid  = 1'b1;
      step();
      req_valid = 1'b0;
      nickels = 8'd99; dimes = 8'd99; quarters = 8'd99;
      load = 1'b1;
      step();
      chk("ld_disp_coin1", int'(coin_out), 4);
      load = 1'b0;
      step();
      chk("ld_disp_coin2", int'(coin_out), 4);
      chk("ld_disp_done", int'(done), 1);
      chk("ld_disp_nickels", int'(nickel_count), 5);
      chk("ld_disp_dimes", int'(dime_count), 5);
      chk("ld_disp_quarters", int'(quarter_count), 3);
      load = 1'b1;
      #1;
      chk("ld_idle_ready", int'(req_ready), 0);
      load = 1'b0;
      #1;
      chk("ld_idle_ready_back", int'(req_ready), 1);

      // asynchronous reset after the first of three coins
      do_load(3, 0, 0);
      req_amount = AMT_W'(3);
      req_valid  = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      chk("mid_first_coin", int'(coin_out), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_coin", int'(coin_out), 0);
      chk("mid_rst_nickels", int'(nickel_count), 0);
      chk("mid_rst_done_short", int'({done, short}), 0);
      step();
      chk("mid_rst_hold_coin", int'(coin_out), 0);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_ready", int'(req_ready), 1);
      orv = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         orv |= int'({coin_out, done, short});
      end
      chk("mid_rst_no_pulse", orv, 0);

      // randomized requests against the reference model
      m_n = 0; m_d = 0; m_q = 0;
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            m_n = $urandom_range(0, 6);
            m_d = $urandom_range(0, 6);
            m_q = $urandom_range(0, 6);
            do_load(m_n, m_d, m_q);
         end
         begin
            int amt;
            amt = $urandom_range(0, 40);
            model_req(amt, e_res, e_samt);
            run_req(amt, edges, res, samt);
            e_edges = exp_q.size() + ((e_res == 2 || amt == 0) ? 1 : 0);
            chk($sformatf("r%0d_result", it), res, e_res);
            chk($sformatf("r%0d_edges", it), edges, e_edges);
            chk($sformatf("r%0d_coins", it), seen.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < seen.size(); k++)
               if (seen[k] != exp_q[k]) chk($sformatf("r%0d_coin%0d", it, k), seen[k], exp_q[k]);
            if (e_res == 2) chk($sformatf("r%0d_short_amount", it), samt, e_samt);
            chk($sformatf("r%0d_counts", it),
                int'({nickel_count, dime_count, quarter_count}), (m_n << 16) | (m_d << 8) | m_q);
            chk($sformatf("r%0d_low", it), int'(low),
                (int'(m_q <= 2) << 2) | (int'(m_d <= 2) << 1) | int'(m_n <= 2));
         end
         if ($urandom_range(0, 1) == 1) step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
